// File: rtl/prog_loader_mem.sv
// Unified 15-bit instruction/data memory with a byte-pair program loader in front.
// Holds the core in reset while loading, then serves same-cycle fetches, loads and stores.
module prog_loader_mem #(
    parameter int DEPTH   = 256,   // address width is fixed at 8, so only 256 is meaningful
    parameter bit LOAD_EN = 1'b1
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_reset,
    input  logic [7:0]  cpu_adr,
    input  logic        cpu_mem_write,
    input  logic [7:0]  cpu_wdata,
    output logic [14:0] cpu_rdata,
    output logic        load_done,
    output logic        load_err,
    output logic        load_ovf,
    output logic [8:0]  word_count
);

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_addr;
    logic [6:0]  r_hi;
    logic        r_cpu_reset;
    logic        r_load_err;
    logic        r_load_ovf;
    logic [8:0]  r_word_count;
    logic [14:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_ld_we;
    logic [14:0] w_ld_wdata;
    logic        w_cpu_we;

    // ld_ready is gated by reset so no byte is ever taken on a reset edge.
    assign ld_ready = !reset && (r_state != RUN);
    assign w_accept = ld_valid && ld_ready;
    assign w_cpu_we = !reset && (r_state == RUN) && !r_cpu_reset && cpu_mem_write;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_ld_we    = 1'b0;
        w_ld_wdata = {ld_data[6:0], 8'h00};
        if (w_accept) begin
            if (r_state == LOAD_LO) begin
                w_ld_we    = 1'b1;
                w_ld_wdata = {r_hi, ld_data};
            end else if (ld_last) begin
                w_ld_we    = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state      <= LOAD_EN ? LOAD_HI : RUN;
            r_addr       <= 8'd0;
            r_word_count <= 9'd0;
            r_load_err   <= 1'b0;
            r_load_ovf   <= 1'b0;
            r_cpu_reset  <= 1'b1;
        end else begin
            // One extra cycle of core reset after the loader hands over.
            r_cpu_reset <= (r_state != RUN);
            case (r_state)
                LOAD_HI: begin
                    if (w_accept) begin
                        r_hi <= ld_data[6:0];
                        if (ld_last) begin
                            r_word_count <= r_word_count + 9'd1;
                            r_load_err   <= 1'b1;
                            r_state      <= RUN;
                        end else begin
                            r_state <= LOAD_LO;
                        end
                    end
                end
                LOAD_LO: begin
                    if (w_accept) begin
                        r_word_count <= r_word_count + 9'd1;
                        r_addr       <= r_addr + 8'd1;
                        if (ld_last) begin
                            r_state <= RUN;
                        end else if (r_addr == 8'hFF) begin
                            r_load_ovf <= 1'b1;
                            r_state    <= RUN;
                        end else begin
                            r_state <= LOAD_HI;
                        end
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // NOTE: the memory array has no reset; contents survive reset so a partial load stays visible.
    always_ff @(posedge ph1) begin
        if (w_ld_we) begin
            r_mem[r_addr] <= w_ld_wdata;
        end else if (w_cpu_we) begin
            r_mem[cpu_adr] <= {r_mem[cpu_adr][14:8], cpu_wdata};
        end
    end

    assign cpu_rdata  = r_mem[cpu_adr];
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = (r_state == RUN);
    assign load_err   = r_load_err;
    assign load_ovf   = r_load_ovf;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Bench for prog_loader_mem: a byte-count-based model checked every cycle,
// plus directed loads, overflow, core stores and mid-load reset with literal expectations.
`timescale 1ns/1ps
module tb_prog_loader_mem;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_reset;
    logic [7:0]  cpu_adr = 8'h00;
    logic        cpu_mem_write = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [14:0] cpu_rdata;
    logic        load_done;
    logic        load_err;
    logic        load_ovf;
    logic [8:0]  word_count;

    int n_tests = 0;
    int n_fail  = 0;

    prog_loader_mem #(.DEPTH(256), .LOAD_EN(1'b1)) dut (
        .ph1(ph1), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_reset(cpu_reset), .cpu_adr(cpu_adr), .cpu_mem_write(cpu_mem_write),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .load_done(load_done), .load_err(load_err), .load_ovf(load_ovf),
        .word_count(word_count)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the load is a numbered byte stream; byte k lands in word k/2.
    logic [14:0] m_mem [256];
    bit          m_known [256];
    bit          m_valid = 1'b0;
    bit          m_done, m_err, m_ovf;
    int          m_nbytes, m_wc, m_run_edges;
    logic [7:0]  m_hi;

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge ph1);
            if (reset) begin
                m_valid = 1'b1; m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
                m_nbytes = 0; m_wc = 0; m_run_edges = 0;
            end else if (m_valid) begin
                if (m_done) begin
                    if (m_run_edges >= 1 && cpu_mem_write && m_known[cpu_adr])
                        m_mem[cpu_adr][7:0] = cpu_wdata;
                    m_run_edges++;
                end else if (ld_valid) begin
                    if (m_nbytes % 2 == 0) begin
                        m_hi = ld_data;
                        if (ld_last) begin
                            m_mem[m_nbytes / 2] = {ld_data[6:0], 8'h00};
                            m_known[m_nbytes / 2] = 1'b1;
                            m_wc++; m_err = 1'b1; m_done = 1'b1;
                        end
                    end else begin
                        m_mem[m_nbytes / 2] = {m_hi[6:0], ld_data};
                        m_known[m_nbytes / 2] = 1'b1;
                        m_wc++;
                        if (ld_last) m_done = 1'b1;
                        else if (m_nbytes == 511) begin m_ovf = 1'b1; m_done = 1'b1; end
                    end
                    m_nbytes++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge ph1);
            if (m_valid) begin
                check("cmp_ld_ready",  ld_ready,  !reset && !m_done);
                check("cmp_cpu_reset", cpu_reset, !(m_done && m_run_edges >= 1));
                check("cmp_load_done", load_done, m_done);
                check("cmp_load_err",  load_err,  m_err);
                check("cmp_load_ovf",  load_ovf,  m_ovf);
                check("cmp_word_count", word_count, m_wc);
                if (m_known[cpu_adr]) check("cmp_rdata", cpu_rdata, m_mem[cpu_adr]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All driving tasks start and end just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge ph1); check("rst_ld_ready", ld_ready, 0);
        @(posedge ph1); #1;
        @(negedge ph1);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_word_count", word_count, 0);
        check("rst_load_done", load_done, 0);
        @(posedge ph1); #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit last, input int gap);
        bit got = 1'b0;
        for (int g = 0; g < gap; g++) begin
            ld_valid = 1'b0; ld_data = 8'($urandom); ld_last = 1'($urandom);
            @(posedge ph1); #1;
        end
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        for (int n = 0; n < 20; n++) begin
            @(negedge ph1);
            if (ld_ready) begin got = 1'b1; break; end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge ph1); #1;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'($urandom);
    endtask

    task automatic read_chk(input string name, input logic [7:0] adr, input logic [14:0] exp);
        cpu_adr = adr;
        @(negedge ph1); check(name, cpu_rdata, exp);
        @(posedge ph1); #1;
    endtask

    function automatic logic [7:0] ovf_hi(input int i);
        if (i == 16) return 8'h3C;
        return {i[0], i[6:0]};
    endfunction

    function automatic logic [7:0] ovf_lo(input int i);
        if (i == 16) return 8'h00;
        return ~i[7:0];
    endfunction

    initial begin
        @(posedge ph1); #1;

        // Basic load; a core store held during the load must be ignored.
        do_reset();
        cpu_adr = 8'h00; cpu_wdata = 8'h99; cpu_mem_write = 1'b1;
        send(8'h12, 0, 0); send(8'h34, 0, 0); send(8'h01, 0, 0); send(8'hFF, 1, 0);
        cpu_mem_write = 1'b0;
        @(negedge ph1);
        check("t1_cpu_reset_hold", cpu_reset, 1);
        check("t1_load_done", load_done, 1);
        @(posedge ph1); #1;
        @(negedge ph1); check("t1_cpu_reset_fall", cpu_reset, 0);
        @(posedge ph1); #1;
        read_chk("t1_mem0", 8'h00, 15'h1234);
        read_chk("t1_mem1", 8'h01, 15'h01FF);
        check("t1_word_count", word_count, 2);
        check("t1_load_err", load_err, 0);

        // Gapped handshakes, bit 7 of the high byte dropped.
        do_reset();
        send(8'h92, 0, 2); send(8'h55, 0, 1); send(8'h03, 0, 3); send(8'h04, 1, 2);
        read_chk("t2_mem0", 8'h00, 15'h1255);
        read_chk("t2_mem1", 8'h01, 15'h0304);
        check("t2_word_count", word_count, 2);

        // Odd-length program.
        do_reset();
        send(8'h05, 0, 0); send(8'h66, 0, 0); send(8'h7F, 1, 0);
        read_chk("t3_mem0", 8'h00, 15'h0566);
        read_chk("t3_mem1", 8'h01, 15'h7F00);
        check("t3_load_err", load_err, 1);
        check("t3_word_count", word_count, 2);
        check("t3_load_done", load_done, 1);

        // Overflow: 512 bytes, no ld_last; store on the cpu_reset-high cycle is ignored.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(ovf_hi(i), 0, 0);
            send(ovf_lo(i), 0, 0);
        end
        cpu_adr = 8'h20; cpu_wdata = 8'h77; cpu_mem_write = 1'b1;
        @(negedge ph1); check("t4_cpu_reset_hold", cpu_reset, 1);
        @(posedge ph1); #1;
        cpu_mem_write = 1'b0;
        check("t4_load_ovf", load_ovf, 1);
        check("t4_word_count", word_count, 256);
        check("t4_load_err", load_err, 0);
        read_chk("t4_mem20_nostore", 8'h20, 15'h20DF);
        ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge ph1); check("t4_no_accept", ld_ready, 0);
        end
        @(posedge ph1); #1;
        ld_valid = 1'b0;
        read_chk("t4_mem0", 8'h00, 15'h00FF);
        read_chk("t4_mem1", 8'h01, 15'h01FE);
        cpu_adr = 8'h10; cpu_wdata = 8'hAB; cpu_mem_write = 1'b1;
        @(negedge ph1); check("t4_rdw_old", cpu_rdata, 15'h3C00);
        @(posedge ph1); #1;
        cpu_mem_write = 1'b0;
        @(negedge ph1); check("t4_store_new", cpu_rdata, 15'h3CAB);
        @(posedge ph1); #1;

        // Reset mid-load, then a fresh two-byte load.
        do_reset();
        send(8'hAA, 0, 0); send(8'h11, 0, 0); send(8'h22, 0, 0);
        do_reset();
        check("t5_load_done", load_done, 0);
        send(8'h00, 0, 0); send(8'h09, 1, 0);
        @(posedge ph1); #1;
        read_chk("t5_mem0", 8'h00, 15'h0009);
        read_chk("t5_mem1", 8'h01, 15'h01FE);
        check("t5_word_count", word_count, 1);
        check("t5_cpu_reset", cpu_reset, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
